// File: rtl/alarm_timer_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarm_timer_unit_pkg : shared alarm-clock constants and helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package alarm_timer_unit_pkg;

  localparam int CNT_W          = 9;
  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic time_match(
    input logic [4:0] hour_a,
    input logic [5:0] min_a,
    input logic [4:0] hour_b,
    input logic [5:0] min_b
  );
    return (hour_a == hour_b) && (min_a == min_b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_timer_unit_tick_down_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_down_counter : reloadable, saturating down-counter advanced by Tick
// Rev 1.0
// ---------------------------------------------------------------------------
module tick_down_counter
  import alarm_timer_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  cnt_t i_load,
  input  logic i_en,
  input  logic i_tick,
  output logic o_zero
);

  cnt_t r_count;

  // Disabled counter keeps reloading, so every enable starts a full-length run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= i_load;
    end else if (!i_en) begin
      r_count <= i_load;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - cnt_t'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alarm_timer_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarm_timer_unit : alarm time comparator plus ring and snooze timers
// Rev 1.0
// ---------------------------------------------------------------------------
module alarm_timer_unit
  import alarm_timer_unit_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic [4:0] Hour_cur,
  input  logic [5:0] Min_cur,
  input  logic [4:0] Hour_alm,
  input  logic [5:0] Min_alm,
  input  logic       Alarm_on,
  input  logic       EN_STOP,
  input  logic       EN_SNZ,
  output logic       AA,
  output logic       C0,
  output logic       CS0
);

  logic w_match;
  logic r_aa;
  logic w_ring_zero;
  logic w_snz_zero;

  assign w_match = Alarm_on && time_match(Hour_cur, Min_cur, Hour_alm, Min_alm);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_aa <= 1'b0;
    end else begin
      r_aa <= w_match;
    end
  end

  tick_down_counter u_ring (
    .clk    (Clk),
    .rst    (Reset),
    .i_load (cnt_t'(RING_SEC)),
    .i_en   (EN_STOP),
    .i_tick (Tick),
    .o_zero (w_ring_zero)
  );

  tick_down_counter u_snz (
    .clk    (Clk),
    .rst    (Reset),
    .i_load (cnt_t'(SNOOZE_SEC)),
    .i_en   (EN_SNZ),
    .i_tick (Tick),
    .o_zero (w_snz_zero)
  );

  assign AA  = r_aa;
  assign C0  = w_ring_zero;
  assign CS0 = w_snz_zero;

endmodule
`default_nettype wire

// File: tb/tb_alarm_timer_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alarm_timer_unit : self-checking bench for alarm_timer_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alarm_timer_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b0;
  logic [4:0] Hour_cur = '0;
  logic [5:0] Min_cur = '0;
  logic [4:0] Hour_alm = '0;
  logic [5:0] Min_alm = '0;
  logic       Alarm_on = 1'b0;
  logic       EN_STOP = 1'b0;
  logic       EN_SNZ = 1'b0;
  logic [2:0] aa_o, c0_o, cs0_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  // Three configurations share the stimulus: default, 3/5 and 2/4 seconds.
  alarm_timer_unit dut_a (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Hour_cur(Hour_cur), .Min_cur(Min_cur),
    .Hour_alm(Hour_alm), .Min_alm(Min_alm), .Alarm_on(Alarm_on), .EN_STOP(EN_STOP),
    .EN_SNZ(EN_SNZ), .AA(aa_o[0]), .C0(c0_o[0]), .CS0(cs0_o[0]));

  alarm_timer_unit #(.RING_SEC(3), .SNOOZE_SEC(5)) dut_b (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Hour_cur(Hour_cur), .Min_cur(Min_cur),
    .Hour_alm(Hour_alm), .Min_alm(Min_alm), .Alarm_on(Alarm_on), .EN_STOP(EN_STOP),
    .EN_SNZ(EN_SNZ), .AA(aa_o[1]), .C0(c0_o[1]), .CS0(cs0_o[1]));

  alarm_timer_unit #(.RING_SEC(2), .SNOOZE_SEC(4)) dut_c (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Hour_cur(Hour_cur), .Min_cur(Min_cur),
    .Hour_alm(Hour_alm), .Min_alm(Min_alm), .Alarm_on(Alarm_on), .EN_STOP(EN_STOP),
    .EN_SNZ(EN_SNZ), .AA(aa_o[2]), .C0(c0_o[2]), .CS0(cs0_o[2]));

  // Reference model: ticks seen since the enable last went high; expired when >= length.
  int  ring_len[3] = '{60, 3, 2};
  int  snz_len[3]  = '{300, 5, 4};
  int  ring_ticks[3];
  int  snz_ticks[3];
  bit  aa_m;

  task automatic model_edge();
    if (Reset) begin
      aa_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
        ring_ticks[i] = 0;
        snz_ticks[i]  = 0;
      end
    end else begin
      aa_m = Alarm_on && (int'(Hour_cur) * 60 + int'(Min_cur) == int'(Hour_alm) * 60 + int'(Min_alm));
      for (int i = 0; i < 3; i++) begin
        ring_ticks[i] = EN_STOP ? ((ring_ticks[i] < 1000) ? ring_ticks[i] + int'(Tick) : 1000) : 0;
        snz_ticks[i]  = EN_SNZ  ? ((snz_ticks[i]  < 1000) ? snz_ticks[i]  + int'(Tick) : 1000) : 0;
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic tk, input logic es, input logic ez,
                       input logic ao, input logic [4:0] hc, input logic [5:0] mc);
    Reset = rst; Tick = tk; EN_STOP = es; EN_SNZ = ez; Alarm_on = ao;
    Hour_cur = hc; Min_cur = mc;
  endtask

  typedef struct {
    string      name;
    logic       rst, tick, es, ez, ao;
    logic [4:0] hc;
    logic [5:0] mc;
    logic       aa, c0, cs0;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic rst, input logic tk, input logic es,
                     input logic ez, input logic ao, input logic [4:0] hc, input logic [5:0] mc,
                     input logic aa, input logic c0, input logic cs0);
    vec_t v;
    v.name = n; v.rst = rst; v.tick = tk; v.es = es; v.ez = ez; v.ao = ao;
    v.hc = hc; v.mc = mc; v.aa = aa; v.c0 = c0; v.cs0 = cs0;
    tbl.push_back(v);
  endtask

  initial begin
    logic [4:0] ha;
    logic [5:0] ma;

    // Expected values refer to the 3/5 instance; alarm time is 07:30.
    add("reset0",      1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("reset1",      1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("aa_0729",     0, 0, 0, 0, 1, 7, 29, 0, 0, 0);
    add("aa_0730",     0, 0, 0, 0, 1, 7, 30, 1, 0, 0);
    add("aa_hold",     0, 0, 0, 0, 1, 7, 30, 1, 0, 0);
    add("aa_0731",     0, 0, 0, 0, 1, 7, 31, 0, 0, 0);
    add("aa_off",      0, 0, 0, 0, 0, 7, 30, 0, 0, 0);
    add("aa_rearm",    0, 0, 0, 0, 1, 7, 30, 1, 0, 0);
    add("aa_hour",     0, 0, 0, 0, 1, 8, 30, 0, 0, 0);
    add("ring_t1",     0, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    add("ring_idle",   0, 0, 1, 0, 0, 0,  0, 0, 0, 0);
    add("ring_t2",     0, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    add("ring_t3",     0, 1, 1, 0, 0, 0,  0, 0, 1, 0);
    add("ring_t4",     0, 1, 1, 0, 0, 0,  0, 0, 1, 0);
    add("ring_off",    0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("ring_offtk",  0, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    add("snz_t1",      0, 1, 0, 1, 0, 0,  0, 0, 0, 0);
    add("snz_t2",      0, 1, 0, 1, 0, 0,  0, 0, 0, 0);
    add("snz_drop",    0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("snz_re1",     0, 1, 0, 1, 0, 0,  0, 0, 0, 0);
    add("snz_re2",     0, 1, 0, 1, 0, 0,  0, 0, 0, 0);
    add("snz_re3",     0, 1, 0, 1, 0, 0,  0, 0, 0, 0);
    add("snz_re4",     0, 1, 0, 1, 0, 0,  0, 0, 0, 0);
    add("snz_re5",     0, 1, 0, 1, 0, 0,  0, 0, 0, 1);
    add("snz_hold",    0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
    add("snz_off",     0, 1, 0, 0, 0, 0,  0, 0, 0, 0);

    Hour_alm = 5'd7;
    Min_alm  = 6'd30;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].tick, tbl[i].es, tbl[i].ez, tbl[i].ao, tbl[i].hc, tbl[i].mc);
      step();
      chk({tbl[i].name, ".AA"},  int'(aa_o[1]),  int'(tbl[i].aa));
      chk({tbl[i].name, ".C0"},  int'(c0_o[1]),  int'(tbl[i].c0));
      chk({tbl[i].name, ".CS0"}, int'(cs0_o[1]), int'(tbl[i].cs0));
      if (tbl[i].rst) begin
        chk("reset.ring_cnt", int'(dut_a.u_ring.r_count), 60);
        chk("reset.snz_cnt",  int'(dut_a.u_snz.r_count), 300);
      end
    end

    // Both timers together on the 2/4 instance.
    for (int t = 1; t <= 4; t++) begin
      drive(0, 1, 1, 1, 0, 0, 0);
      step();
      chk($sformatf("dual.t%0d.C0", t),  int'(c0_o[2]),  (t >= 2) ? 1 : 0);
      chk($sformatf("dual.t%0d.CS0", t), int'(cs0_o[2]), (t >= 4) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("dual.off.C0", int'(c0_o[2]), 0);

    // Asynchronous reset between edges while the 3-second ring timer sits at 1.
    drive(0, 1, 1, 0, 0, 0, 0);
    step();
    step();
    chk("async.pre.C0",  int'(c0_o[1]), 0);
    chk("async.pre.cnt", int'(dut_b.u_ring.r_count), 1);
    Tick = 1'b0;
    #3 Reset = 1'b1;
    #1;
    chk("async.C0",  int'(c0_o[1]), 0);
    chk("async.cnt", int'(dut_b.u_ring.r_count), 3);
    Tick = 1'b1;
    #1;
    chk("async.tick_in_reset.C0", int'(c0_o[2]), 0);
    Tick = 1'b0;
    #1 Reset = 1'b0;
    step();
    for (int t = 1; t <= 3; t++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      step();
      chk($sformatf("async.resume.t%0d.C0", t), int'(c0_o[1]), (t == 3) ? 1 : 0);
    end

    // Resynchronise the model, then randomised traffic against it.
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    step();
    ha = 5'($urandom_range(0, 23));
    ma = 6'($urandom_range(0, 59));
    Hour_alm = ha;
    Min_alm  = ma;
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(0, 99) == 0);
      Tick  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) EN_STOP = ~EN_STOP;
      if ($urandom_range(0, 149) == 0) EN_SNZ  = ~EN_SNZ;
      if ($urandom_range(0, 49) == 0)  Alarm_on = ~Alarm_on;
      if ($urandom_range(0, 1) == 0) begin
        Hour_cur = ha;
        Min_cur  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 59)) : ma;
      end else begin
        Hour_cur = 5'($urandom_range(0, 23));
        Min_cur  = 6'($urandom_range(0, 59));
      end
      step();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rand[%0d].AA", i),  int'(aa_o[i]),  int'(aa_m));
        chk($sformatf("rand[%0d].C0", i),  int'(c0_o[i]),  (ring_ticks[i] >= ring_len[i]) ? 1 : 0);
        chk($sformatf("rand[%0d].CS0", i), int'(cs0_o[i]), (snz_ticks[i] >= snz_len[i]) ? 1 : 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_timer_unit.md
ALARM_TIMER_UNIT -- requirements
Module: alarm_timer_unit

Interface
REQ-001 Parameter RING_SEC, default 60: ring-timeout length in Tick periods (1..511).
REQ-002 Parameter SNOOZE_SEC, default 300: snooze length in Tick periods (1..511).
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Tick  input  1  one-Clk-wide 1 Hz enable pulse.
REQ-006 Hour_cur  input  5  current hour, 0..23.
REQ-007 Min_cur  input  6  current minute, 0..59.
REQ-008 Hour_alm  input  5  alarm hour, 0..23.
REQ-009 Min_alm  input  6  alarm minute, 0..59.
REQ-010 Alarm_on  input  1  alarm armed by user.
REQ-011 EN_STOP  input  1  ring-timer enable from alarm control unit.
REQ-012 EN_SNZ  input  1  snooze-timer enable from alarm control unit.
REQ-013 AA  output  1  alarm active (time match), registered.
REQ-014 C0  output  1  ring timer expired.
REQ-015 CS0  output  1  snooze timer expired.

Function
REQ-016 The block SHALL act as the timing responder to the alarm control unit: it consumes EN_STOP/EN_SNZ and produces AA/C0/CS0.
REQ-017 AA SHALL be registered each Clk as Alarm_on AND (Hour_cur==Hour_alm) AND (Min_cur==Min_alm); one-cycle latency from input change.
REQ-018 AA SHALL deassert the cycle after Alarm_on falls or the minute no longer matches.
REQ-019 Ring counter (9 bits) SHALL hold RING_SEC while EN_STOP=0, reloaded on every Clk with EN_STOP=0.
REQ-020 While EN_STOP=1, ring counter SHALL decrement by 1 on each Clk with Tick=1, including the first enabled cycle.
REQ-021 Ring counter SHALL saturate at 0; Tick at 0 leaves it 0.
REQ-022 C0 SHALL equal (ring counter == 0), decoded from the register; rises the cycle after the decrementing Tick edge from 1.
REQ-023 Snooze counter SHALL obey REQ-019..REQ-021 with EN_SNZ and SNOOZE_SEC.
REQ-024 CS0 SHALL equal (snooze counter == 0), same timing as C0.
REQ-025 Deasserting an enable mid-count SHALL reload that counter at the next edge, clearing its flag; re-enable restarts full length.
REQ-026 Both enables high simultaneously SHALL run both counters independently.
REQ-027 Tick with enable low SHALL have no effect on that counter.
REQ-028 C0/CS0 SHALL remain high while enable stays high and counter is 0.

Reset
REQ-029 Reset=1 SHALL immediately force ring counter=RING_SEC, snooze counter=SNOOZE_SEC, AA=0, C0=0, CS0=0.
REQ-030 Reset asserted mid-count SHALL abort the count; after release, counting resumes from full length on enabled Ticks.
REQ-031 No output SHALL toggle during Reset regardless of Clk, Tick or enables.

Structure
REQ-032 RING_SEC, SNOOZE_SEC defaults and CNT_W=9 SHALL live in the shared alarm-clock constants include used by the control units.
REQ-033 One sub-module tick_down_counter (load value, enable, tick, count, zero flag) SHALL be instantiated twice; the AA comparator stays in the top.

Verification
REQ-034 Reset=1 for 2 Clk, all inputs 0 -> AA=C0=CS0=0, counters 60/300.
REQ-035 Alarm_on=1, Hour_alm=7/Min_alm=30, cur steps 07:29->07:30->07:31 -> AA 0, 1 one Clk after 07:30, 0 one Clk after 07:31.
REQ-036 RING_SEC=3, EN_STOP=1, three Tick pulses -> C0 high the Clk after third Tick; fourth Tick keeps C0=1, count 0.
REQ-037 SNOOZE_SEC=5, EN_SNZ=1, 2 Ticks, EN_SNZ=0 for 1 Clk, EN_SNZ=1, 5 Ticks -> CS0 stays 0 until the 5th post-re-enable Tick, then 1.
REQ-038 EN_STOP=EN_SNZ=1, RING_SEC=2, SNOOZE_SEC=4, 4 Ticks -> C0 rises after Tick 2, CS0 after Tick 4.
REQ-039 Count in progress (ring=1), Reset pulsed asynchronously between edges -> C0=0 and counter=RING_SEC before next Clk edge.
